// File: rtl/rc5_pkg.sv
// RC5-32 shared constants, FSM state encoding and the 32-bit rotate helper.
// Pure declarations: no latency and no flow control of its own.
package rc5_pkg;

    localparam int W      = 32;
    localparam int ROUNDS = 12;
    localparam int NKEY   = 2 * ROUNDS + 2;
    localparam int CW     = 4;
    localparam int AW     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Left-circular rotate: the upper word of {x,x}<<sh holds the wrapped bits.
    function automatic logic [W-1:0] rotl32(input logic [W-1:0] x, input logic [4:0] sh);
        logic [2*W-1:0] dbl;
        dbl = {x, x} << sh;
        return dbl[2*W-1:W];
    endfunction

endpackage

// File: rtl/rc5_encrypt_core_if.sv
// Plaintext/ciphertext handshake and key-write bundle for rc5_encrypt_core.
// Valid/ready on both data paths; key writes carry no backpressure.
interface rc5_encrypt_core_if;
    import rc5_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  pt;
    logic            key_we;
    logic [AW-1:0]   key_addr;
    logic [W-1:0]    key_data;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out;
    logic            busy;

    modport master (
        output in_valid, pt, key_we, key_addr, key_data, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, pt, key_we, key_addr, key_data, out_ready,
        output in_ready, out_valid, out, busy
    );

endinterface

// File: rtl/rc5_round.sv
// One full RC5 round (both half-rounds), purely combinational.
// Zero latency; no flow control.
module rc5_round
    import rc5_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] s_even,
    input  logic [W-1:0] s_odd,
    output logic [W-1:0] a_nxt,
    output logic [W-1:0] b_nxt
);

    assign a_nxt = rotl32(a ^ b, b[4:0]) + s_even;
    assign b_nxt = rotl32(b ^ a_nxt, a_nxt[4:0]) + s_odd;

endmodule

// File: rtl/rc5_encrypt_core.sv
// Iterative RC5-32/12 encryptor, one round per clock; ciphertext valid ROUNDS edges after accept.
// Holds the result in DONE until out_ready; no new plaintext is taken until then.
module rc5_encrypt_core
    import rc5_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    rc5_encrypt_core_if.slave  bus
);

    state_t          state_q, state_d;
    logic [CW-1:0]   rnd_q;
    logic [W-1:0]    a_q, b_q;
    logic [W-1:0]    a_nxt, b_nxt;
    logic [W-1:0]    skey_q [NKEY];
    logic [2*W-1:0]  out_q;
    logic [AW-1:0]   idx_even, idx_odd;
    logic            key_wr_ok;
    logic            last_rnd;

    assign idx_even  = {rnd_q, 1'b0};
    assign idx_odd   = {rnd_q, 1'b1};
    assign key_wr_ok = bus.key_we && (bus.key_addr < AW'(NKEY));
    assign last_rnd  = (rnd_q == CW'(ROUNDS));

    rc5_round u_round (
        .a      (a_q),
        .b      (b_q),
        .s_even (skey_q[idx_even]),
        .s_odd  (skey_q[idx_odd]),
        .a_nxt  (a_nxt),
        .b_nxt  (b_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = ROUND;
            ROUND:   if (last_rnd)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state_q)
            IDLE:    bus.in_ready  = 1'b1;
            ROUND:   bus.busy      = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: bus.in_ready  = 1'b0;
        endcase
    end

    // Whitening reads the registered table, so a same-edge write to S[0]/S[1] lands after use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            rnd_q <= '0;
            out_q <= '0;
            for (int k = 0; k < NKEY; k++) skey_q[k] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (key_wr_ok) skey_q[bus.key_addr] <= bus.key_data;
                    if (bus.in_valid) begin
                        a_q   <= bus.pt[W-1:0]   + skey_q[0];
                        b_q   <= bus.pt[2*W-1:W] + skey_q[1];
                        rnd_q <= CW'(1);
                    end
                end
                ROUND: begin
                    a_q <= a_nxt;
                    b_q <= b_nxt;
                    if (last_rnd) out_q <= {b_nxt, a_nxt};
                    else          rnd_q <= rnd_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_rc5_encrypt_core.sv
// Directed and randomized checks of rc5_encrypt_core against an arithmetic RC5 model.
module tb_rc5_encrypt_core;

    localparam int NR = 12;
    localparam int NK = 2 * NR + 2;

    logic clk;
    logic rst;

    rc5_encrypt_core_if bus ();

    rc5_encrypt_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks;
    int          failures;
    int          cyc;
    logic [31:0] sk [NK];
    logic [63:0] exp_ct, ct, held, p;
    logic [31:0] nv;
    bit          bad;

    function automatic logic [31:0] rl(input logic [31:0] x, input int s);
        int r;
        r = s % 32;
        if (r == 0) return x;
        return (x << r) | (x >> (32 - r));
    endfunction

    function automatic logic [63:0] model_enc(input logic [63:0] ptv);
        logic [31:0] a, b;
        a = ptv[31:0] + sk[0];
        b = ptv[63:32] + sk[1];
        for (int r = 1; r <= NR; r++) begin
            a = rl(a ^ b, int'(b[4:0])) + sk[2*r];
            b = rl(b ^ a, int'(a[4:0])) + sk[2*r+1];
        end
        return {b, a};
    endfunction

    // Standard RC5 key schedule for a 16-byte all-zero key.
    task automatic expand_zero_key();
        logic [31:0] l [4];
        logic [31:0] ka, kb, t;
        int ii, jj;
        for (int k = 0; k < 4; k++) l[k] = 32'h0;
        sk[0] = 32'hB7E15163;
        for (int k = 1; k < NK; k++) sk[k] = sk[k-1] + 32'h9E3779B9;
        ka = 0; kb = 0; ii = 0; jj = 0;
        for (int k = 0; k < 3 * NK; k++) begin
            sk[ii] = rl(sk[ii] + ka + kb, 3);
            ka = sk[ii];
            t = ka + kb;
            l[jj] = rl(l[jj] + ka + kb, int'(t[4:0]));
            kb = l[jj];
            ii = (ii + 1) % NK;
            jj = (jj + 1) % 4;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.pt        = '0;
        bus.key_we    = 1'b0;
        bus.key_addr  = '0;
        bus.key_data  = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic write_key(input logic [4:0] addr, input logic [31:0] data);
        bus.key_we   = 1'b1;
        bus.key_addr = addr;
        bus.key_data = data;
        tick();
        bus.key_we   = 1'b0;
        if (int'(addr) < NK) sk[addr] = data;
    endtask

    task automatic load_random_table();
        for (int k = 0; k < NK; k++) write_key(5'(k), $urandom);
    endtask

    task automatic load_table();
        for (int k = 0; k < NK; k++) write_key(5'(k), sk[k]);
    endtask

    task automatic start_enc(input logic [63:0] ptv);
        bus.pt       = ptv;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_done(input string tag, input logic [63:0] want);
        bit busy_bad;
        busy_bad = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) busy_bad = 1;
            tick();
        end
        chk({tag, " latency"}, 64'(cyc), 64'(NR));
        chk({tag, " in_ready/busy in ROUND"}, 64'(busy_bad), 64'd0);
        chk({tag, " ciphertext"}, bus.out, want);
        chk({tag, " DONE flags"}, {61'd0, bus.in_ready, bus.busy, bus.out_valid}, 64'd1);
    endtask

    task automatic handshake(input string tag);
        logic [63:0] keep;
        keep = bus.out;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, " post-handshake flags"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        chk({tag, " out held"}, bus.out, keep);
    endtask

    task automatic run_enc(input string tag, input logic [63:0] ptv);
        logic [63:0] want;
        want = model_enc(ptv);
        start_enc(ptv);
        wait_done(tag, want);
        handshake(tag);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        idle_inputs();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid  = 1'($urandom);
            bus.pt        = {$urandom, $urandom};
            bus.key_we    = 1'($urandom);
            bus.key_addr  = 5'($urandom);
            bus.key_data  = $urandom;
            bus.out_ready = 1'($urandom);
            tick();
        end
        chk("reset out", bus.out, 64'h0);
        chk("reset flags", {61'd0, bus.in_ready, bus.out_valid, bus.busy}, 64'd4);
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < NK; k++) sk[k] = 32'h0;
        tick();

        run_enc("zero pt0", 64'h0);

        // Intermediate round values on an all-zero table.
        start_enc(64'h1);
        tick();
        chk("round1 A", 64'(dut.a_q), 64'h1);
        chk("round1 B", 64'(dut.b_q), 64'h2);
        tick();
        chk("round2 A", 64'(dut.a_q), 64'hC);
        chk("round2 B", 64'(dut.b_q), 64'hE000);
        wait_done("zero pt1", model_enc(64'h1));
        handshake("zero pt1");

        expand_zero_key();
        load_table();
        start_enc(64'h0);
        wait_done("known answer", 64'h6D8F4B15_EEDBA521);
        handshake("known answer");

        for (int n = 0; n < 3; n++) begin
            load_random_table();
            for (int m = 0; m < 2; m++) run_enc("random", {$urandom, $urandom});
        end

        // Backpressure: result must sit still while in_valid is hammered.
        p = {$urandom, $urandom};
        start_enc(p);
        wait_done("backpressure", model_enc(p));
        held = bus.out;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            bus.in_valid = 1'b1;
            bus.pt       = {$urandom, $urandom};
            tick();
            if (bus.out_valid !== 1'b1 || bus.out !== held || bus.in_ready !== 1'b0) bad = 1;
        end
        bus.in_valid = 1'b0;
        chk("backpressure hold", 64'(bad), 64'd0);
        handshake("backpressure");
        tick();
        chk("no stray start", {62'd0, bus.busy, bus.out_valid}, 64'd0);

        p = {$urandom, $urandom};
        exp_ct = model_enc(p);
        start_enc(p);
        for (int k = 0; k < 6; k++) begin
            bus.key_we   = 1'b1;
            bus.key_addr = 5'($urandom_range(NK - 1, 0));
            bus.key_data = $urandom;
            tick();
        end
        bus.key_we = 1'b0;
        wait_done("key write in ROUND", exp_ct);
        handshake("key write in ROUND");

        write_key(5'd26, $urandom);
        write_key(5'd31, $urandom);
        run_enc("out-of-range key write", {$urandom, $urandom});

        // Same-edge write to S[0]: whitening uses the old word, the table keeps the new one.
        p = {$urandom, $urandom};
        nv = $urandom;
        exp_ct = model_enc(p);
        bus.key_we = 1'b1; bus.key_addr = 5'd0; bus.key_data = nv;
        bus.pt = p; bus.in_valid = 1'b1;
        tick();
        idle_inputs();
        cyc = 0;
        sk[0] = nv;
        wait_done("same-edge S0", exp_ct);
        handshake("same-edge S0");
        run_enc("S0 stored", {$urandom, $urandom});

        p = {$urandom, $urandom};
        nv = $urandom;
        sk[4] = nv;
        exp_ct = model_enc(p);
        bus.key_we = 1'b1; bus.key_addr = 5'd4; bus.key_data = nv;
        bus.pt = p; bus.in_valid = 1'b1;
        tick();
        idle_inputs();
        cyc = 0;
        wait_done("same-edge S4", exp_ct);
        handshake("same-edge S4");

        // Reset partway through an encryption.
        start_enc({$urandom, $urandom});
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < NK; k++) sk[k] = 32'h0;
        chk("mid reset out", bus.out, 64'h0);
        chk("mid reset flags", {61'd0, bus.in_ready, bus.out_valid, bus.busy}, 64'd4);
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out !== 64'h0) bad = 1;
        end
        chk("mid reset quiet", 64'(bad), 64'd0);
        run_enc("after mid reset", {$urandom, $urandom});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
